pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS32 core.
- Merges stall requests from IF, ID, EX and MEM into the 6-bit stall vector that each pipeline register samples.
  - Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.
- Sequences multi-cycle EX operations (madd/msub/div) with an internal down-counter.
- Issues a one-cycle flush on exception.

Parameters:
- CNT_W, 6, width of multi-cycle length and counter.
- STALL_W, 6, stall vector width; fixed at 6, kept for readability.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  fetch not ready.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  single-cycle EX hold request.
- stallreq_mem  in  1  data memory not ready.
- ex_mc_start  in  1  EX starts a multi-cycle op this cycle.
- ex_mc_cycles  in  CNT_W  total EX occupancy N of that op.
- flush_req  in  1  exception detected in MEM.
- stall  out  STALL_W  stall vector (1 = Stop).
- flush  out  1  clear all pipeline registers.
- mc_busy  out  1  multi-cycle op in progress.
- mc_done  out  1  last cycle of multi-cycle op; EX result valid.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0.
  - stall=6'b000000, flush=0, mc_busy=0, mc_done=0.
  - Reset mid-operation aborts the op with no mc_done.
- State machine, registered (state, cnt); outputs combinational from state, cnt and inputs.
  - IDLE, ex_mc_start=1, N>=2: cnt<=N-1, state<=RUN. This cycle counts as an EX stall.
  - IDLE, ex_mc_start=1, N<=1: single-cycle op, no stall, no state change.
  - RUN, cnt>1: EX stall asserted, cnt<=cnt-1.
  - RUN, cnt==1: mc_done=1, no multi-cycle stall, state<=IDLE.
  - ex_mc_start in RUN is ignored, because EX is held.
  - Net effect: an N-cycle op asserts stall for N-1 cycles; mc_done is on cycle N.
- mc_busy = (state==RUN) or accepted start in IDLE.
- Stall priority: deepest source wins; vectors are not ORed per bit.
  - flush_req: 000000 (flush has precedence over all stalls).
  - stallreq_mem: 011111.
  - stallreq_ex or multi-cycle EX stall: 001111.
  - stallreq_id: 000111.
  - stallreq_if: 000011.
  - none: 000000.
- Flush:
  - flush = flush_req, combinational, same cycle.
  - Forces state<=IDLE and cnt<=0.
  - No mc_done is asserted in that cycle.
- flush_req and ex_mc_start in the same cycle: flush wins; start is discarded.
- stallreq_mem during RUN:
  - stall=011111 and cnt is frozen, so the EX op does not advance while MEM is stalled.
  - Counting resumes when the MEM stall drops.
- Stage downstream of the highest stalled stage sees a bubble: the register of stage k outputs NOP when stall[k]=1 and stall[k+1]=0.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - N is latched at start; the input is not re-sampled.
  - Max N = 2^CNT_W - 1.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0] and input perf_clr.
  - Counter increments every cycle in which stall != 0; wraps at 2^32.
  - Synchronous clear on perf_clr; perf_clr has priority over the increment.
  - Async reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared defines header holds:
  - Stop/NoStop values.
  - RstEnable redefined to 1'b0 for this block.
  - The five stall-vector constants: STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - State encodings: IDLE=1'b0, RUN=1'b1.
- One natural sub-module: pipe_ctrl_mc_cnt (multi-cycle counter plus FSM, inputs start/N/freeze/abort, outputs busy/done/stall_ex).
- Priority encode and flush stay in the top module.

Test Plan:
- Reset mid-RUN (start N=5, pull rst low on cycle 2) -> stall=000000, mc_busy=0 immediately; no mc_done after release.
- stallreq_id=1 alone for 1 cycle -> stall=000111 that cycle; with stallreq_mem=1 simultaneously -> stall=011111.
- ex_mc_start, N=4 -> stall=001111 for 3 cycles, mc_done=1 on 4th cycle with stall=000000, then IDLE; N=1 -> no stall, no mc_done.
- Start N=6, stallreq_mem=1 for 2 cycles on cycle 2 -> stall=011111 on those cycles; mc_done delayed to cycle 8.
- Start N=8, flush_req on cycle 3 -> flush=1, stall=000000 that cycle; mc_busy=0 next cycle; never mc_done. Flush concurrent with start -> no RUN entry.
- PIPE_CTRL_PERF_EN: N=4 op plus 2 ID stalls -> stall_cycles=5; perf_clr -> 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the MIPS32 pipeline controller: stop levels, reset
// level, the five stall-vector encodings and the multi-cycle FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b0;   // reset is active-low in this block

    localparam int STALL_WIDTH = 6;

    // Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB
    localparam logic [STALL_WIDTH-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_WIDTH-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_WIDTH-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_WIDTH-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_cnt.sv
// Multi-cycle EX sequencer (madd/msub/div). An N-cycle op holds EX for N-1
// cycles and flags done on cycle N. freeze holds the count while MEM is
// stalled; abort (flush) drops the op without a done pulse.
module pipe_ctrl_mc_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic             freeze,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             stall_ex
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and remaining-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and sequencer outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        stall_ex = NO_STOP;
        case (state_q)
            IDLE: begin
                // N is latched here; the start cycle itself is an EX stall
                if (start && !abort && n >= CNT_W'(2)) begin
                    state_d  = RUN;
                    cnt_d    = n - CNT_W'(1);
                    busy     = 1'b1;
                    stall_ex = STOP;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q > CNT_W'(1)) begin
                    stall_ex = STOP;
                    if (!freeze) cnt_d = cnt_q - CNT_W'(1);
                end else if (!freeze) begin
                    // final cycle only completes once MEM lets the pipe move
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage MIPS32 core: priority-encodes stall
// requests into the per-register stall vector, sequences multi-cycle EX ops
// and passes exceptions through as a same-cycle flush.
// Optional stall-cycle performance counter under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PIPE_CTRL_PERF_EN
    input  logic               perf_clr,
    output logic [31:0]        stall_cycles,
`endif
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               ex_mc_start,
    input  logic [CNT_W-1:0]   ex_mc_cycles,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               mc_busy,
    output logic               mc_done
);

    logic mc_busy_w, mc_done_w, mc_stall_ex;

    pipe_ctrl_mc_cnt #(.CNT_W(CNT_W)) u_mc_cnt (
        .clk      (clk),
        .rst      (rst),
        .start    (ex_mc_start),
        .n        (ex_mc_cycles),
        .freeze   (stallreq_mem),
        .abort    (flush_req),
        .busy     (mc_busy_w),
        .done     (mc_done_w),
        .stall_ex (mc_stall_ex)
    );

    // Deepest stalled stage wins; flush overrides every stall
    always_comb begin
        stall   = STALL_NONE;
        flush   = flush_req;
        mc_busy = mc_busy_w;
        mc_done = mc_done_w;
        if (flush_req)                        stall = STALL_NONE;
        else if (stallreq_mem)                stall = STALL_MEM;
        else if (stallreq_ex || mc_stall_ex)  stall = STALL_EX;
        else if (stallreq_id)                 stall = STALL_ID;
        else if (stallreq_if)                 stall = STALL_IF;
        // hold every control output quiet while reset is applied
        if (rst == RST_ENABLE) begin
            stall   = STALL_NONE;
            flush   = 1'b0;
            mc_busy = 1'b0;
            mc_done = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Clear beats increment; wraps naturally at 2^32
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr)          stall_cycles_d = '0;
        else if (stall != '0)  stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall-cycle counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cycles_q <= '0;
        else      stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
